// File: rtl/stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// stall_ctrl_if
// Bundles the request/response signals between the pipeline and the stall
// controller. The pipeline side uses the master modport, the stall controller
// uses the slave modport.
//
// Optional feature macro: STALL_ACK_EN (adds mem_ack for variable-latency SRAM)
//
// Signals
//   stall_req_id  pipeline -> ctrl  load-use hazard request from ID
//   mem_req       pipeline -> ctrl  instruction in MEM accesses data memory
//   mem_ack       pipeline -> ctrl  SRAM access complete (STALL_ACK_EN only)
//   clr_cnt       pipeline -> ctrl  synchronous clear of the stall counter
//   stall         ctrl -> pipeline  per-stage freeze vector [0]pc .. [5]wb
//   busy          ctrl -> pipeline  controller is in the WAIT state
//   stall_cycles  ctrl -> pipeline  saturating count of stalled cycles
// ---------------------------------------------------------------------------
interface stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall_req_id;
  logic             mem_req;
`ifdef STALL_ACK_EN
  logic             mem_ack;
`endif
  logic             clr_cnt;
  logic [5:0]       stall;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

`ifdef STALL_ACK_EN
  modport master (
    output stall_req_id, mem_req, mem_ack, clr_cnt,
    input  stall, busy, stall_cycles
  );
  modport slave (
    input  stall_req_id, mem_req, mem_ack, clr_cnt,
    output stall, busy, stall_cycles
  );
`else
  modport master (
    output stall_req_id, mem_req, clr_cnt,
    input  stall, busy, stall_cycles
  );
  modport slave (
    input  stall_req_id, mem_req, clr_cnt,
    output stall, busy, stall_cycles
  );
`endif
endinterface

// File: rtl/stall_ctrl.sv
// ---------------------------------------------------------------------------
// stall_ctrl
// Pipeline stall controller. Produces the stall vector sampled by pc_reg,
// if_id, id_ex, ex_mem and mem_wb. Bit k high freezes stage k; bit k high
// with bit k+1 low makes the k/k+1 register insert a bubble.
// The ID load-use request is merged with MEM data accesses that share the
// instruction/data SRAM bus; while a data access owns the bus the whole
// pipeline through MEM is frozen, and its final bus cycle inserts an IF
// bubble because fetch could not use the bus. Stalled cycles are counted
// for performance debug.
//
// Optional feature macro: STALL_ACK_EN
//   undefined : fixed access latency of MEM_WAIT_CYCLES bus cycles
//   defined   : access ends on mem_ack; MEM_WAIT_CYCLES is ignored
//
// Parameters
//   MEM_WAIT_CYCLES  bus cycles per data access, 1..15 (fixed-latency mode)
//   CNT_W            width of the stall-cycle counter
//
// Ports
//   clk   clock, single domain
//   rst   synchronous active-high reset
//   bus   stall_ctrl_if.slave: requests in, stall/busy/stall_cycles out
//         (stall is combinational so pipeline registers react at the same
//          edge; busy and stall_cycles are registered)
// ---------------------------------------------------------------------------
module stall_ctrl #(
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int CNT_W           = 16
) (
  input  logic          clk,
  input  logic          rst,
  stall_ctrl_if.slave   bus
);

  // Stall patterns
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_FRZ  = 6'b011111; // freeze through MEM, bubble into WB
  localparam logic [5:0] STALL_IFB  = 6'b000011; // pc/if_id hold, bubble into ID
  localparam logic [5:0] STALL_LDU  = 6'b000111; // hold through ID, bubble into EX

  localparam logic [3:0] WAIT_CNT_MAX = 4'hF;
  localparam logic [4:0] WAIT_TOTAL   = 5'(MEM_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       wait_cnt_r;      // bus cycles of the current access already completed
  logic [3:0]       wait_cnt_nxt_s;
  logic [3:0]       wait_cnt_inc_s;
  logic             busy_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [5:0]       stall_s;
  logic [5:0]       ldu_s;
  logic             final_s;

  // Load-use pattern contributed by ID; it never overrides a freeze
  always_comb begin
    if (bus.stall_req_id) begin
      ldu_s = STALL_LDU;
    end else begin
      ldu_s = STALL_NONE;
    end
  end

  // Saturating increment of the bus-cycle counter
  always_comb begin
    if (wait_cnt_r == WAIT_CNT_MAX) begin
      wait_cnt_inc_s = WAIT_CNT_MAX;
    end else begin
      wait_cnt_inc_s = wait_cnt_r + 4'd1;
    end
  end

`ifdef STALL_ACK_EN
  // Variable latency: the SRAM acknowledge marks the final bus cycle.
  // An acknowledge without a request is ignored by the request checks below.
  always_comb begin
    final_s = bus.mem_req && bus.mem_ack;
  end
`else
  // Fixed latency: wait_cnt_r is 0 in IDLE, so this also covers a
  // single-cycle access started from IDLE.
  always_comb begin
    if (({1'b0, wait_cnt_r} + 5'd1) == WAIT_TOTAL) begin
      final_s = 1'b1;
    end else begin
      final_s = 1'b0;
    end
  end
`endif

  // Next-state and stall vector decode
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    stall_s        = STALL_NONE;

    if (rst) begin
      // Any access in flight is abandoned; the pipeline is not stalled.
      state_nxt_s    = ST_IDLE;
      wait_cnt_nxt_s = 4'd0;
      stall_s        = STALL_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!bus.mem_req) begin
            stall_s        = ldu_s;
            state_nxt_s    = ST_IDLE;
            wait_cnt_nxt_s = 4'd0;
          end else if (final_s) begin
            // Single-cycle access: fetch lost the bus this cycle.
            stall_s        = STALL_IFB | ldu_s;
            state_nxt_s    = ST_IDLE;
            wait_cnt_nxt_s = 4'd0;
          end else begin
            // Freeze dominates a simultaneous ID request.
            stall_s        = STALL_FRZ;
            state_nxt_s    = ST_WAIT;
            wait_cnt_nxt_s = 4'd1;
          end
        end
        ST_WAIT: begin
          if (!bus.mem_req) begin
            // Access aborted (e.g. flushed instruction): release the pipe.
            stall_s        = ldu_s;
            state_nxt_s    = ST_IDLE;
            wait_cnt_nxt_s = 4'd0;
          end else if (final_s) begin
            // Final cycle always returns to IDLE; a request in the next
            // cycle belongs to the following instruction.
            stall_s        = STALL_IFB | ldu_s;
            state_nxt_s    = ST_IDLE;
            wait_cnt_nxt_s = 4'd0;
          end else begin
            stall_s        = STALL_FRZ;
            state_nxt_s    = ST_WAIT;
            wait_cnt_nxt_s = wait_cnt_inc_s;
          end
        end
        default: begin
          stall_s        = STALL_NONE;
          state_nxt_s    = ST_IDLE;
          wait_cnt_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // FSM state, bus-cycle counter and registered busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      busy_r     <= (state_nxt_s == ST_WAIT);
    end
  end

  // Saturating stall-cycle counter; clear wins over a concurrent stall
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= '0;
    end else if (bus.clr_cnt) begin
      stall_cycles_r <= '0;
    end else if ((stall_s != STALL_NONE) && (stall_cycles_r != CNT_MAX)) begin
      stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.busy         = busy_r;
  assign bus.stall_cycles = stall_cycles_r;

endmodule
